// File: rtl/board_serial_capture.sv
// board_serial_capture: serial-to-parallel receiver for the clock/clear/data
// shift-register stream driven into the board LED and 7-segment drivers.
// The serial lines are oversampled on clk; each completed word is offered
// through a valid/ack handshake with a sticky overrun flag and a one-cycle
// err pulse when a partial frame is abandoned after a serial clock stall.
module board_serial_capture #(
  parameter int P_CLK_FREQ   = 100,
  parameter int S_CLK_FREQ   = 20,
  parameter int DATA_BITS    = 16,
  parameter int CODE_ENDIAN  = 1,
  parameter int TIMEOUT_CLKS = 4 * P_CLK_FREQ / S_CLK_FREQ
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_clk,
  input  logic                 s_clr,
  input  logic                 s_dat,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ack,
  output logic                 busy,
  output logic                 overrun,
  output logic                 err
);

  localparam int CNT_W = (DATA_BITS < 2) ? 1 : $clog2(DATA_BITS + 1);
  localparam int TO_W  = (TIMEOUT_CLKS < 2) ? 1 : $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Synchronizer and edge-detect flops
  logic r_clk_s1, r_clk_s2, r_clk_s3;
  logic r_clr_s1, r_clr_s2;
  logic r_dat_s1, r_dat_s2;

  // Frame assembly state
  state_t               r_state;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [TO_W-1:0]      r_to_cnt;
  logic [DATA_BITS-1:0] r_shift;

  // Output registers
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_overrun;
  logic                 r_err;

  // Next-state signals
  state_t               w_state_next;
  logic [CNT_W-1:0]     w_bit_cnt_next;
  logic [TO_W-1:0]      w_to_cnt_next;
  logic [DATA_BITS-1:0] w_shift_next;
  logic                 w_complete;
  logic                 w_err_next;

  logic                 w_edge;
  logic                 w_clr;
  logic                 w_dat;
  logic [DATA_BITS-1:0] w_base;
  logic [DATA_BITS-1:0] w_shifted;

  assign w_edge = r_clk_s2 & ~r_clk_s3;
  assign w_clr  = r_clr_s2;
  assign w_dat  = r_dat_s2;

  // A new frame always starts from an all-zero word so stale partial bits
  // left behind by a timeout or clear can never leak into the next frame.
  assign w_base = (r_state == ST_IDLE) ? '0 : r_shift;

  // Whole-vector shifts keep the DATA_BITS=1 case legal and use every bit.
  assign w_shifted = (CODE_ENDIAN != 0)
                   ? ((w_base << 1) | DATA_BITS'(w_dat))
                   : ((w_base >> 1) | (DATA_BITS'(w_dat) << (DATA_BITS - 1)));

  // Bring the asynchronous serial lines into the clk domain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_clk_s1 <= 1'b0;
      r_clk_s2 <= 1'b0;
      r_clk_s3 <= 1'b0;
      r_clr_s1 <= 1'b0;
      r_clr_s2 <= 1'b0;
      r_dat_s1 <= 1'b0;
      r_dat_s2 <= 1'b0;
    end else begin
      r_clk_s1 <= s_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_s3 <= r_clk_s2;
      r_clr_s1 <= s_clr;
      r_clr_s2 <= r_clr_s1;
      r_dat_s1 <= s_dat;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Frame FSM state, bit counter, stall counter and shift register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_to_cnt  <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_to_cnt  <= w_to_cnt_next;
      r_shift   <= w_shift_next;
    end
  end

  // Next-state logic: clear dominates, then edges, then the stall timeout
  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt;
    w_to_cnt_next  = r_to_cnt;
    w_shift_next   = r_shift;
    w_complete     = 1'b0;
    w_err_next     = 1'b0;

    if (w_clr) begin
      w_state_next   = ST_IDLE;
      w_bit_cnt_next = '0;
      w_to_cnt_next  = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_bit_cnt_next = '0;
          w_to_cnt_next  = '0;
          if (w_edge) begin
            w_shift_next = w_shifted;
            if (DATA_BITS == 1) begin
              w_complete = 1'b1;
            end else begin
              w_state_next   = ST_SHIFT;
              w_bit_cnt_next = CNT_W'(1);
            end
          end
        end
        ST_SHIFT: begin
          if (w_edge) begin
            w_shift_next  = w_shifted;
            w_to_cnt_next = '0;
            if (r_bit_cnt == CNT_W'(DATA_BITS - 1)) begin
              w_complete     = 1'b1;
              w_state_next   = ST_IDLE;
              w_bit_cnt_next = '0;
            end else begin
              w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
            end
          end else if (r_to_cnt == TO_W'(TIMEOUT_CLKS - 1)) begin
            w_err_next     = 1'b1;
            w_state_next   = ST_IDLE;
            w_bit_cnt_next = '0;
            w_to_cnt_next  = '0;
          end else begin
            w_to_cnt_next = r_to_cnt + TO_W'(1);
          end
        end
        default: begin
          w_state_next   = ST_IDLE;
          w_bit_cnt_next = '0;
          w_to_cnt_next  = '0;
        end
      endcase
    end
  end

  // Output word, handshake and status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_err_next;
      if (w_complete) begin
        r_data  <= w_shift_next;
        r_valid <= 1'b1;
        if (r_valid && !ack) begin
          r_overrun <= 1'b1;
        end else if (r_valid && ack) begin
          r_overrun <= 1'b0;
        end
      end else if (r_valid && ack) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end
    end
  end

  assign data    = r_data;
  assign valid   = r_valid;
  assign overrun = r_overrun;
  assign err     = r_err;
  assign busy    = (r_state == ST_SHIFT);

endmodule

// File: tb/tb_board_serial_capture.sv
// Directed testbench for board_serial_capture: two instances (MSB-first and
// LSB-first) share the serial lines; expected values are hand-computed.
module tb_board_serial_capture;

  localparam int TIMEOUT_CLKS = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_clk;
  logic        s_clr;
  logic        s_dat;
  logic        ack;
  logic [15:0] data;
  logic        valid;
  logic        busy;
  logic        overrun;
  logic        err;
  logic [15:0] data_le;
  logic        valid_le;
  logic        busy_le;
  logic        overrun_le;
  logic        err_le;

  int checks   = 0;
  int failures = 0;
  int err_cnt  = 0;
  int err_base = 0;

  always #5 clk = ~clk;

  board_serial_capture #(
    .P_CLK_FREQ(100), .S_CLK_FREQ(20), .DATA_BITS(16), .CODE_ENDIAN(1),
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .s_clk(s_clk), .s_clr(s_clr), .s_dat(s_dat),
    .data(data), .valid(valid), .ack(ack), .busy(busy),
    .overrun(overrun), .err(err)
  );

  board_serial_capture #(
    .P_CLK_FREQ(100), .S_CLK_FREQ(20), .DATA_BITS(16), .CODE_ENDIAN(0),
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_dut_le (
    .clk(clk), .rst_n(rst_n), .s_clk(s_clk), .s_clr(s_clr), .s_dat(s_dat),
    .data(data_le), .valid(valid_le), .ack(ack), .busy(busy_le),
    .overrun(overrun_le), .err(err_le)
  );

  // Count cycles in which the MSB-first instance reports err
  always @(posedge clk) begin
    if (err === 1'b1) err_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One serial bit: data set with clock low, 2 cycles setup, 3 cycles high
  task automatic send_bit(input logic b);
    s_clk = 1'b0;
    s_dat = b;
    repeat (2) @(negedge clk);
    s_clk = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Sends the low n bits of v, most significant of those first
  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    s_clk = 1'b0;
    s_clr = 1'b0;
    s_dat = 1'b0;
    ack   = 1'b0;
    repeat (4) @(negedge clk);

    // Reset state
    check("rst_data", data, 16'h0000);
    check("rst_valid", valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_err", err, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 0xA5C3 MSB first with latency check on the final bit
    send_bits(16'h52E1, 15);
    check("a5_busy_mid", busy, 1'b1);
    s_clk = 1'b0;
    s_dat = 1'b1;
    repeat (2) @(negedge clk);
    s_clk = 1'b1;
    @(negedge clk);
    check("lat_edge1", valid, 1'b0);
    @(negedge clk);
    check("lat_edge2", valid, 1'b0);
    @(negedge clk);
    check("lat_edge3", valid, 1'b1);
    check("a5_data", data, 16'hA5C3);
    check("a5_busy_end", busy, 1'b0);
    check("le_data", data_le, 16'hC3A5);
    check("le_valid", valid_le, 1'b1);
    do_ack();
    check("a5_ack_valid", valid, 1'b0);
    check("a5_ack_ovr", overrun, 1'b0);

    // 7 bits then a stall longer than the timeout
    send_bits(16'h0055, 7);
    check("to_busy_mid", busy, 1'b1);
    err_base = err_cnt;
    s_clk = 1'b0;
    repeat (TIMEOUT_CLKS + 2) @(negedge clk);
    check("to_err_pulses", err_cnt - err_base, 1);
    check("to_err_now", err, 1'b0);
    check("to_busy", busy, 1'b0);
    check("to_valid", valid, 1'b0);
    send_bits(16'h1234, 16);
    check("to_next_data", data, 16'h1234);
    check("to_next_valid", valid, 1'b1);
    do_ack();

    // 9 bits, clear pulse, then a full frame
    err_base = err_cnt;
    send_bits(16'h0155, 9);
    s_clr = 1'b1;
    repeat (4) @(negedge clk);
    check("clr_busy", busy, 1'b0);
    check("clr_data_held", data, 16'h1234);
    s_clr = 1'b0;
    repeat (3) @(negedge clk);
    send_bits(16'hFFFF, 16);
    check("clr_data", data, 16'hFFFF);
    check("clr_valid", valid, 1'b1);
    check("clr_no_err", err_cnt - err_base, 0);
    do_ack();

    // Two frames without ack -> overrun
    send_bits(16'h0001, 16);
    send_bits(16'h0002, 16);
    check("ovr_data", data, 16'h0002);
    check("ovr_valid", valid, 1'b1);
    check("ovr_flag", overrun, 1'b1);
    do_ack();
    check("ovr_ack_valid", valid, 1'b0);
    check("ovr_ack_flag", overrun, 1'b0);

    // Ack in the completion cycle of the second frame
    send_bits(16'h0001, 16);
    check("ack2_valid1", valid, 1'b1);
    send_bits(16'h0001, 15);
    s_clk = 1'b0;
    s_dat = 1'b0;
    repeat (2) @(negedge clk);
    s_clk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("ack2_data", data, 16'h0002);
    check("ack2_valid", valid, 1'b1);
    check("ack2_ovr", overrun, 1'b0);

    // Reset in mid-frame, then 0xBEEF
    err_base = err_cnt;
    send_bits(16'h02FB, 10);
    check("mr_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    s_clk = 1'b0;
    repeat (2) @(negedge clk);
    check("mr_data", data, 16'h0000);
    check("mr_valid", valid, 1'b0);
    check("mr_busy", busy, 1'b0);
    check("mr_overrun", overrun, 1'b0);
    check("mr_err", err, 1'b0);
    check("mr_le_data", data_le, 16'h0000);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_bits(16'h5F77, 15);
    check("mr_no_valid", valid, 1'b0);
    send_bit(1'b1);
    check("mr_beef_data", data, 16'hBEEF);
    check("mr_beef_valid", valid, 1'b1);
    check("mr_no_err", err_cnt - err_base, 0);
    check("mr_busy_end", busy, 1'b0);
    do_ack();
    check("mr_ack_valid", valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
